// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Read-mode encodings and the occupancy-counter width function.
package fifo_sync_pkg;

    localparam int READ_MODE_STD  = 0;
    localparam int READ_MODE_FWFT = 1;

    // One extra bit so a counter or pointer can tell full from empty.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset; only the read register is cleared.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// Define FIFO_SYNC_ERR_STICKY_EN for sticky overflow/underflow flags.
module fifo_sync_fwft
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 16,
    parameter int READ_MODE         = READ_MODE_STD,
    parameter int PROG_FULL_THRESH  = 12,
    parameter int PROG_EMPTY_THRESH = 4,
    localparam int CW               = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  data_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [CW-1:0]         data_count,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PFULL_C = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PEMPT_C = CW'(PROG_EMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] wr_ptr_d, wr_ptr_q;
    logic [CW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    logic [CW-1:0] mem_cnt;
    logic          ov_d, ov_q;
    logic          full_d, full_q;
    logic          afull_d, afull_q;
    logic          empty_d, empty_q;
    logic          aempty_d, aempty_q;
    logic          pfull_d, pfull_q;
    logic          pempty_d, pempty_q;
    logic          dvalid_d, dvalid_q;
    logic          wr_ack_d, wr_ack_q;
    logic          ovf_d, ovf_q;
    logic          udf_d, udf_q;
    logic          wr_ok, rd_ok;
    logic          ovf_ev, udf_ev;
    logic          ram_re;

`ifndef FIFO_SYNC_ERR_STICKY_EN
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
`endif

    always_comb begin
        wr_ok   = wr_en & ~full_q;
        rd_ok   = rd_en & ~empty_q;
        ovf_ev  = wr_en & full_q;
        udf_ev  = rd_en & empty_q;
        mem_cnt = wr_ptr_q - rd_ptr_q;
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);

        if (READ_MODE == READ_MODE_FWFT) begin
            // RAM read register doubles as the prefetch/output register.
            ram_re   = (mem_cnt != '0) && (!ov_q || rd_ok);
            ov_d     = ram_re | (ov_q & ~rd_ok);
            empty_d  = ~ov_d;
            dvalid_d = ov_d;
        end else begin
            ram_re   = rd_ok;
            ov_d     = 1'b0;
            empty_d  = (count_d == '0);
            dvalid_d = rd_ok;
        end

        wr_ptr_d = wr_ptr_q + CW'(wr_ok);
        rd_ptr_d = rd_ptr_q + CW'(ram_re);

        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= ONE_C);
        pfull_d  = (count_d >= PFULL_C);
        pempty_d = (count_d <= PEMPT_C);
        wr_ack_d = wr_ok;

`ifdef FIFO_SYNC_ERR_STICKY_EN
        ovf_d = (ovf_q & ~err_clr) | ovf_ev;
        udf_d = (udf_q & ~err_clr) | udf_ev;
`else
        ovf_d = ovf_ev;
        udf_d = udf_ev;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            pfull_q  <= 1'b0;
            pempty_q <= 1'b1;
            dvalid_q <= 1'b0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_q     <= ov_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            pfull_q  <= pfull_d;
            pempty_q <= pempty_d;
            dvalid_q <= dvalid_d;
            wr_ack_q <= wr_ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (wr_ok),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (dout)
    );

    assign data_valid   = dvalid_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign prog_full    = pfull_q;
    assign prog_empty   = pempty_q;
    assign data_count   = count_q;
    assign wr_ack       = wr_ack_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench: one standard-mode and one FWFT-mode FIFO instance.
module tb_fifo_sync_fwft;

`ifdef FIFO_SYNC_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        err_clr = 1'b0;

    logic [63:0] din_s = '0, din_f = '0;
    logic        wr_s = 1'b0, rd_s = 1'b0;
    logic        wr_f = 1'b0, rd_f = 1'b0;

    logic [63:0] s_dout, f_dout;
    logic        s_dv, s_full, s_af, s_empty, s_ae, s_pf, s_pe;
    logic        s_ack, s_ovf, s_udf;
    logic [4:0]  s_cnt;
    logic        f_dv, f_full, f_af, f_empty, f_ae, f_pf, f_pe;
    logic        f_ack, f_ovf, f_udf;
    logic [4:0]  f_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fifo_sync_fwft #(.READ_MODE(0)) u_std (
        .clk(clk), .rstn(rstn), .din(din_s), .wr_en(wr_s), .rd_en(rd_s),
        .err_clr(err_clr), .dout(s_dout), .data_valid(s_dv),
        .full(s_full), .almost_full(s_af), .empty(s_empty),
        .almost_empty(s_ae), .prog_full(s_pf), .prog_empty(s_pe),
        .data_count(s_cnt), .wr_ack(s_ack), .overflow(s_ovf),
        .underflow(s_udf)
    );

    fifo_sync_fwft #(.READ_MODE(1)) u_fwft (
        .clk(clk), .rstn(rstn), .din(din_f), .wr_en(wr_f), .rd_en(rd_f),
        .err_clr(err_clr), .dout(f_dout), .data_valid(f_dv),
        .full(f_full), .almost_full(f_af), .empty(f_empty),
        .almost_empty(f_ae), .prog_full(f_pf), .prog_empty(f_pe),
        .data_count(f_cnt), .wr_ack(f_ack), .overflow(f_ovf),
        .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_s();
        chk("s_rst_full", s_full, 0);
        chk("s_rst_af", s_af, 0);
        chk("s_rst_pf", s_pf, 0);
        chk("s_rst_empty", s_empty, 1);
        chk("s_rst_ae", s_ae, 1);
        chk("s_rst_pe", s_pe, 1);
        chk("s_rst_cnt", s_cnt, 0);
        chk("s_rst_dout", s_dout, 0);
        chk("s_rst_dv", s_dv, 0);
        chk("s_rst_ack", s_ack, 0);
        chk("s_rst_ovf", s_ovf, 0);
        chk("s_rst_udf", s_udf, 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_s();
        chk("f_rst_empty", f_empty, 1);
        chk("f_rst_dv", f_dv, 0);
        chk("f_rst_cnt", f_cnt, 0);
        chk("f_rst_dout", f_dout, 0);
        rstn = 1'b1;
        tick();

        // Fill standard FIFO with 0..15
        for (int i = 0; i < 16; i++) begin
            din_s = 64'(i);
            wr_s  = 1'b1;
            tick();
            chk("fill_ack", s_ack, 1);
            chk("fill_cnt", s_cnt, 64'(i + 1));
            chk("fill_pf", s_pf, 64'((i + 1) >= 12));
            chk("fill_pe", s_pe, 64'((i + 1) <= 4));
            chk("fill_af", s_af, 64'((i + 1) >= 15));
            chk("fill_full", s_full, 64'((i + 1) == 16));
            chk("fill_empty", s_empty, 0);
        end

        // Overflow on the 17th write
        din_s = 64'd16;
        tick();
        chk("ovf_pulse", s_ovf, 1);
        chk("ovf_ack", s_ack, 0);
        chk("ovf_cnt", s_cnt, 16);
        wr_s = 1'b0;
        tick();
        chk("ovf_after", s_ovf, 64'(STICKY));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", s_ovf, 0);

        // Read and write together at count 16
        din_s = 64'd99;
        wr_s  = 1'b1;
        rd_s  = 1'b1;
        tick();
        wr_s = 1'b0;
        chk("rw_full_cnt", s_cnt, 15);
        chk("rw_full_ovf", s_ovf, 1);
        chk("rw_full_dout", s_dout, 0);
        chk("rw_full_dv", s_dv, 1);
        chk("rw_full_full", s_full, 0);

        // Drain the rest: 1..15, write of 99 was rejected
        err_clr = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            err_clr = 1'b0;
            chk("drain_dout", s_dout, 64'(k));
            chk("drain_dv", s_dv, 1);
        end
        chk("drain_cnt", s_cnt, 0);
        chk("drain_empty", s_empty, 1);
        tick();
        rd_s = 1'b0;
        chk("udf_pulse", s_udf, 1);
        chk("udf_dout", s_dout, 15);
        chk("udf_empty", s_empty, 1);
        chk("udf_dv", s_dv, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", s_udf, 0);

        // FWFT two-edge fall-through
        din_f = 64'hA5;
        wr_f  = 1'b1;
        tick();
        wr_f = 1'b0;
        chk("fw_n_cnt", f_cnt, 1);
        chk("fw_n_empty", f_empty, 1);
        chk("fw_n_dv", f_dv, 0);
        tick();
        chk("fw_n1_dout", f_dout, 64'hA5);
        chk("fw_n1_dv", f_dv, 1);
        chk("fw_n1_empty", f_empty, 0);
        chk("fw_n1_cnt", f_cnt, 1);
        rd_f = 1'b1;
        tick();
        chk("fw_pop_dv", f_dv, 0);
        chk("fw_pop_empty", f_empty, 1);
        chk("fw_pop_cnt", f_cnt, 0);

        // FWFT streaming with rd_en held high
        din_f = 64'd1;
        wr_f  = 1'b1;
        tick();
        chk("fw_s0_udf", f_udf, 1);
        chk("fw_s0_cnt", f_cnt, 1);
        chk("fw_s0_dv", f_dv, 0);
        din_f = 64'd2;
        tick();
        chk("fw_s1_dout", f_dout, 1);
        chk("fw_s1_dv", f_dv, 1);
        chk("fw_s1_cnt", f_cnt, 2);
        din_f = 64'd3;
        tick();
        wr_f = 1'b0;
        chk("fw_s2_dout", f_dout, 2);
        chk("fw_s2_dv", f_dv, 1);
        chk("fw_s2_cnt", f_cnt, 2);
        tick();
        chk("fw_s3_dout", f_dout, 3);
        chk("fw_s3_dv", f_dv, 1);
        chk("fw_s3_cnt", f_cnt, 1);
        tick();
        rd_f = 1'b0;
        chk("fw_s4_dv", f_dv, 0);
        chk("fw_s4_empty", f_empty, 1);
        chk("fw_s4_cnt", f_cnt, 0);
        chk("fw_s4_dout", f_dout, 3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Count 5 steady state with pointer wrap
        wr_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din_s = 64'(100 + i);
            tick();
        end
        chk("wrap_pre_cnt", s_cnt, 5);
        rd_s = 1'b1;
        for (int k = 0; k < 100; k++) begin
            din_s = 64'(105 + k);
            tick();
            chk("wrap_dout", s_dout, 64'(100 + k));
            chk("wrap_cnt", s_cnt, 5);
        end

        // Asynchronous reset mid-stream
        rstn = 1'b0;
        #1;
        chk_reset_s();
        wr_s = 1'b0;
        rd_s = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_empty", s_empty, 1);
        chk("post_rst_cnt", s_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
